// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational wrap-around priority search: first requester at or above ptr.
module rr_picker
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_WD   = clog2_min1(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_WD-1:0]   ptr,
    output logic [ID_WD-1:0]   gnt_idx,
    output logic               gnt_vld
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!gnt_vld && req[i] && (i >= int'(ptr))) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_WD'(i);
            end
        end
        // Nothing at or above ptr: wrap to the low indices.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!gnt_vld && req[i] && (i < int'(ptr))) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_WD'(i);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC AXI-Stream sources onto one
// master through a single output register stage.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int DATA_WD = 64,
    parameter  int NUM_SRC = 4,
    localparam int ID_WD   = clog2_min1(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    input  logic [NUM_SRC*DATA_WD-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [DATA_WD-1:0]         m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [ID_WD-1:0]           m_axis_tid,
    input  logic                       m_axis_tready,
    output logic                       busy
);

    arb_state_e         state;
    logic [ID_WD-1:0]   grant;
    logic [ID_WD-1:0]   rr_ptr;
    logic [ID_WD-1:0]   pick_idx;
    logic               pick_vld;
    logic               sel_valid;
    logic               sel_last;
    logic [DATA_WD-1:0] sel_data;
    logic               out_free;
    logic               accept;
    logic [ID_WD-1:0]   next_ptr;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .ID_WD   (ID_WD)
    ) u_picker (
        .req     (s_axis_tvalid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == ID_WD'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_WD +: DATA_WD];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign accept   = (state == LOCK) && out_free && sel_valid;
    assign next_ptr = (grant == ID_WD'(NUM_SRC - 1)) ? '0 : grant + ID_WD'(1);

    always_comb begin
        s_axis_tready = '0;
        if (!rst && (state == LOCK)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant == ID_WD'(i)) begin
                    s_axis_tready[i] = out_free;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            grant         <= '0;
            rr_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant <= pick_idx;
                        state <= LOCK;
                        busy  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (accept && sel_last) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
            endcase

            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= sel_data;
                m_axis_tlast  <= sel_last;
                m_axis_tid    <= grant;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (DATA_WD=64, NUM_SRC=4).
module tb_axis_rr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   s_tvalid;
    logic [255:0] s_tdata;
    logic [3:0]   s_tlast;
    logic [3:0]   s_tready;
    logic         m_tvalid;
    logic [63:0]  m_tdata;
    logic         m_tlast;
    logic [1:0]   m_tid;
    logic         m_tready;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    axis_rr_arbiter #(
        .DATA_WD (64),
        .NUM_SRC (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tready (m_tready),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic src(input int i, input logic v, input logic [63:0] d, input logic l);
        s_tvalid[i]          = v;
        s_tdata[i*64 +: 64]  = d;
        s_tlast[i]           = l;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic       exp_v;
        logic [1:0] exp_tid;

        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata",  m_tdata,  0);
        check("rst_tlast",  m_tlast,  0);
        check("rst_tid",    m_tid,    0);
        check("rst_busy",   busy,     0);
        check("rst_tready", s_tready, 0);

        // All four sources stream single-beat packets: tid 0,1,2,3,0 with idle gaps
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) src(i, 1'b1, 64'h10 + 64'(i), 1'b1);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) next_cycle();
            sample();
            exp_v   = (k >= 2) && (k % 2 == 0);
            exp_tid = 2'(((k - 2) / 2) % 4);
            check("a_tvalid", m_tvalid, exp_v);
            check("a_busy",   busy,     (k % 2) == 1);
            check("a_tready", s_tready, (k % 2 == 1) ? (64'd1 << (((k - 1) / 2) % 4)) : 64'd0);
            if (exp_v) begin
                check("a_tid",   m_tid,   exp_tid);
                check("a_tdata", m_tdata, 64'h10 + 64'(exp_tid));
            end
        end

        // Source 2 three-beat packet, source 0 joins and is served via wrap from ptr 3
        do_reset();
        src(2, 1'b1, 64'hA0, 1'b0);
        sample();
        check("b_idle_busy", busy, 0);
        next_cycle();
        src(0, 1'b1, 64'h55, 1'b1);
        sample();
        check("b_lock_tready", s_tready, 4'b0100);
        check("b_lock_busy",   busy,     1);
        next_cycle();
        src(2, 1'b1, 64'hA1, 1'b0);
        sample();
        check("b_beat0_tvalid", m_tvalid, 1);
        check("b_beat0_tdata",  m_tdata,  64'hA0);
        check("b_beat0_tid",    m_tid,    2);
        check("b_beat0_tlast",  m_tlast,  0);
        next_cycle();
        src(2, 1'b1, 64'hA2, 1'b1);
        sample();
        check("b_beat1_tdata",  m_tdata,  64'hA1);
        check("b_beat1_tid",    m_tid,    2);
        check("b_beat1_tready", s_tready, 4'b0100);
        next_cycle();
        src(2, 1'b0, 64'h0, 1'b0);
        sample();
        check("b_beat2_tdata",  m_tdata,  64'hA2);
        check("b_beat2_tlast",  m_tlast,  1);
        check("b_beat2_tid",    m_tid,    2);
        check("b_gap_busy",     busy,     0);
        check("b_gap_tready",   s_tready, 0);
        next_cycle();
        sample();
        check("b_wrap_tvalid", m_tvalid, 0);
        check("b_wrap_busy",   busy,     1);
        check("b_wrap_tready", s_tready, 4'b0001);
        next_cycle();
        src(0, 1'b0, 64'h0, 1'b0);
        sample();
        check("b_src0_tvalid", m_tvalid, 1);
        check("b_src0_tid",    m_tid,    0);
        check("b_src0_tdata",  m_tdata,  64'h55);

        // Five cycles of master backpressure inside a source 1 packet
        do_reset();
        src(1, 1'b1, 64'hB0, 1'b0);
        sample();
        next_cycle();
        sample();
        check("c_lock_tready", s_tready, 4'b0010);
        next_cycle();
        src(1, 1'b1, 64'hB1, 1'b0);
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            sample();
            check("c_hold_tvalid", m_tvalid, 1);
            check("c_hold_tdata",  m_tdata,  64'hB0);
            check("c_hold_tready", s_tready, 0);
        end
        next_cycle();
        m_tready = 1'b1;
        sample();
        check("c_release_tready", s_tready, 4'b0010);
        check("c_release_tdata",  m_tdata,  64'hB0);
        next_cycle();
        src(1, 1'b1, 64'hB2, 1'b1);
        sample();
        check("c_b1_tdata", m_tdata, 64'hB1);
        check("c_b1_tlast", m_tlast, 0);
        next_cycle();
        src(1, 1'b0, 64'h0, 1'b0);
        sample();
        check("c_b2_tdata", m_tdata, 64'hB2);
        check("c_b2_tlast", m_tlast, 1);
        check("c_b2_busy",  busy,    0);
        next_cycle();
        sample();
        check("c_drain_tvalid", m_tvalid, 0);

        // Source 1 stalls mid-packet; source 3 must wait for source 1's tlast
        do_reset();
        src(1, 1'b1, 64'hC0, 1'b0);
        src(3, 1'b1, 64'hD0, 1'b1);
        sample();
        next_cycle();
        sample();
        check("d_grant_tready", s_tready, 4'b0010);
        next_cycle();
        src(1, 1'b0, 64'hC0, 1'b0);
        sample();
        check("d_c0_tdata", m_tdata, 64'hC0);
        check("d_c0_tid",   m_tid,   1);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            sample();
            check("d_stall_tvalid", m_tvalid, 0);
            check("d_stall_busy",   busy,     1);
            check("d_stall_tready", s_tready, 4'b0010);
        end
        next_cycle();
        src(1, 1'b1, 64'hC1, 1'b1);
        sample();
        check("d_resume_tready", s_tready, 4'b0010);
        next_cycle();
        src(1, 1'b0, 64'h0, 1'b0);
        sample();
        check("d_c1_tdata", m_tdata, 64'hC1);
        check("d_c1_tlast", m_tlast, 1);
        check("d_c1_busy",  busy,    0);
        next_cycle();
        sample();
        check("d_src3_tready", s_tready, 4'b1000);
        next_cycle();
        src(3, 1'b0, 64'h0, 1'b0);
        sample();
        check("d_src3_tid",   m_tid,   3);
        check("d_src3_tdata", m_tdata, 64'hD0);

        // Reset during beat 2 of a source 3 packet
        do_reset();
        src(3, 1'b1, 64'hE0, 1'b0);
        sample();
        next_cycle();
        sample();
        next_cycle();
        src(3, 1'b1, 64'hE1, 1'b0);
        sample();
        check("e_e0_tdata",  m_tdata,  64'hE0);
        check("e_e0_tready", s_tready, 4'b1000);
        rst = 1'b1;
        #1;
        check("e_rst_tready", s_tready, 0);
        next_cycle();
        rst = 1'b0;
        src(1, 1'b1, 64'hF0, 1'b1);
        sample();
        check("e_after_tvalid", m_tvalid, 0);
        check("e_after_busy",   busy,     0);
        check("e_after_tdata",  m_tdata,  0);
        next_cycle();
        sample();
        check("e_regrant_tready", s_tready, 4'b0010);
        next_cycle();
        src(1, 1'b0, 64'h0, 1'b0);
        sample();
        check("e_f0_tid",   m_tid,   1);
        check("e_f0_tdata", m_tdata, 64'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
